// File: rtl/rs_alu_sched_pkg.sv
// rs_alu_sched_pkg: shared ALU reservation-station constants and helpers
`ifndef ALU_ENT_NUM
`define ALU_ENT_NUM 8
`endif
`ifndef ALU_ENT_SEL
`define ALU_ENT_SEL 3
`endif

package rs_alu_sched_pkg;
    localparam int ALU_ENT_NUM = `ALU_ENT_NUM;
    localparam int ALU_ENT_SEL = `ALU_ENT_SEL;

    // Number of dispatch slots requesting an entry this cycle (0..2).
    function automatic logic [1:0] req_count(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction
endpackage

// File: rtl/rs_alu_sched_prio_enc.sv
// rs_prio_enc: find-first-set (lowest index) with valid flag
//   req   - request vector
//   valid - any bit of req set
//   idx   - lowest set bit index, 0 when req is empty
module rs_prio_enc #(
    parameter int W   = 8,
    parameter int SEL = 3
) (
    input  logic [W-1:0]   req,
    output logic           valid,
    output logic [SEL-1:0] idx
);
    always_comb begin
        valid = |req;
        idx   = '0;
        for (int i = W - 1; i >= 0; i--)
            if (req[i]) idx = SEL'(i);
    end
endmodule

// File: rtl/rs_alu_sched.sv
// rs_alu_sched: ALU reservation-station allocation and round-robin issue scheduler
//   clk_i, reset_ni          - clock, asynchronous active-low reset
//   flush_i                  - empties the station, kills this cycle's grant/issue
//   alloc_req_1/2_i          - dispatch slot requests (slot 2 only with slot 1)
//   alloc_ok_o, alloc_*_idx_o, we_vec_o - all-or-nothing grant and entry write enables
//   busy_vec_o, free_count_o - entry occupancy
//   ready_vec_i              - per-entry operand-ready flags
//   issue_valid_o/idx_o/ready_i - valid/ready handshake to the ALU execute stage
`ifndef ALU_ENT_NUM
`define ALU_ENT_NUM 8
`endif
`ifndef ALU_ENT_SEL
`define ALU_ENT_SEL 3
`endif

module rs_alu_sched
    import rs_alu_sched_pkg::*;
#(
    parameter int ENTRY_NUM = `ALU_ENT_NUM,
    parameter int ENTRY_SEL = `ALU_ENT_SEL
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 flush_i,
    input  logic                 alloc_req_1_i,
    input  logic                 alloc_req_2_i,
    output logic                 alloc_ok_o,
    output logic [ENTRY_SEL-1:0] alloc_1_idx_o,
    output logic [ENTRY_SEL-1:0] alloc_2_idx_o,
    output logic [ENTRY_NUM-1:0] we_vec_o,
    output logic [ENTRY_NUM-1:0] busy_vec_o,
    output logic [ENTRY_SEL:0]   free_count_o,
    input  logic [ENTRY_NUM-1:0] ready_vec_i,
    output logic                 issue_valid_o,
    output logic [ENTRY_SEL-1:0] issue_idx_o,
    input  logic                 issue_ready_i
);
    logic [ENTRY_NUM-1:0] busy;
    logic [ENTRY_SEL-1:0] rr_ptr;

    logic [ENTRY_NUM-1:0] free_vec, free2_vec, cand, hi_mask;
    logic [ENTRY_SEL-1:0] f1_idx, f2_idx, hi_idx, lo_idx;
    logic                 f1_vld, f2_vld, hi_vld, lo_vld, fire;
    logic [1:0]           req_cnt;

    assign free_vec  = ~busy;
    assign free2_vec = free_vec & ~(ENTRY_NUM'(1) << f1_idx);

    rs_prio_enc #(.W(ENTRY_NUM), .SEL(ENTRY_SEL)) u_free1 (.req(free_vec),  .valid(f1_vld), .idx(f1_idx));
    rs_prio_enc #(.W(ENTRY_NUM), .SEL(ENTRY_SEL)) u_free2 (.req(free2_vec), .valid(f2_vld), .idx(f2_idx));

    always_comb begin
        free_count_o = '0;
        for (int i = 0; i < ENTRY_NUM; i++)
            free_count_o = free_count_o + (ENTRY_SEL + 1)'(free_vec[i]);
    end

    assign req_cnt = req_count(alloc_req_1_i, alloc_req_2_i);

    // reset_ni gates the grant so nothing is offered while the station is held in reset
    assign alloc_ok_o    = reset_ni & ~flush_i & (req_cnt != 2'd0)
                           & (free_count_o >= (ENTRY_SEL + 1)'(req_cnt));
    assign alloc_1_idx_o = (reset_ni && f1_vld) ? f1_idx : '0;
    assign alloc_2_idx_o = (reset_ni && f2_vld) ? f2_idx : '0;
    assign we_vec_o      = alloc_ok_o
                           ? ((alloc_req_1_i ? ENTRY_NUM'(1) << f1_idx : '0)
                              | (alloc_req_2_i ? ENTRY_NUM'(1) << f2_idx : '0))
                           : '0;

    // Rotating priority: first look at candidates at or above rr_ptr, else wrap to the lowest.
    assign cand    = ready_vec_i & busy;
    assign hi_mask = ~((ENTRY_NUM'(1) << rr_ptr) - ENTRY_NUM'(1));

    rs_prio_enc #(.W(ENTRY_NUM), .SEL(ENTRY_SEL)) u_iss_hi (.req(cand & hi_mask), .valid(hi_vld), .idx(hi_idx));
    rs_prio_enc #(.W(ENTRY_NUM), .SEL(ENTRY_SEL)) u_iss_lo (.req(cand),           .valid(lo_vld), .idx(lo_idx));

    assign issue_valid_o = lo_vld & ~flush_i;
    assign issue_idx_o   = hi_vld ? hi_idx : lo_idx;
    assign fire          = issue_valid_o & issue_ready_i;
    assign busy_vec_o    = busy;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            busy   <= '0;
            rr_ptr <= '0;
        end else if (flush_i) begin
            busy   <= '0;
            rr_ptr <= '0;
        end else begin
            busy   <= (busy | we_vec_o) & ~(fire ? ENTRY_NUM'(1) << issue_idx_o : '0);
            rr_ptr <= fire ? issue_idx_o + ENTRY_SEL'(1) : rr_ptr;
        end
    end

    a_req2_needs_req1 : assert property (@(posedge clk_i) disable iff (!reset_ni)
        !(alloc_req_2_i && !alloc_req_1_i));
endmodule

// File: doc/rs_alu_sched.md
Name: rs_alu_sched

Overview:
- Allocation and issue scheduler for the ALU reservation station.
- Tracks busy state for each of ENTRY_NUM ALU RS entries and allocates free entries to up to two dispatched instructions per cycle; it drives each entry's busy and write-enable inputs.
- Selects one ready entry per cycle, round-robin, and hands it to the ALU execute stage over a valid/ready handshake.
- Sits between dispatch (upstream) and the RS entry array / ALU execute stage (downstream).

Parameters:
- ENTRY_NUM, 8, number of ALU RS entries; power of two, at least 4.
- ENTRY_SEL, 3, log2(ENTRY_NUM); width of entry indices.

Ports:
- clk_i, input, 1, clock.
- reset_ni, input, 1, asynchronous active-low reset.
- flush_i, input, 1, pipeline kill; empties the station.
- alloc_req_1_i, input, 1, dispatch slot 1 requests an entry.
- alloc_req_2_i, input, 1, dispatch slot 2 requests an entry; legal only together with alloc_req_1_i.
- alloc_ok_o, output, 1, all requested entries granted this cycle.
- alloc_1_idx_o, output, ENTRY_SEL, entry index for slot 1.
- alloc_2_idx_o, output, ENTRY_SEL, entry index for slot 2.
- we_vec_o, output, ENTRY_NUM, one-hot or two-hot write enables; connects to each entry's we_i.
- busy_vec_o, output, ENTRY_NUM, busy flags; connects to each entry's busy_i.
- free_count_o, output, ENTRY_SEL+1, number of non-busy entries.
- ready_vec_i, input, ENTRY_NUM, ready_o from each entry.
- issue_valid_o, output, 1, a ready entry has been selected.
- issue_idx_o, output, ENTRY_SEL, index of the selected entry; drives the execute-operand mux.
- issue_ready_i, input, 1, ALU execute stage accepts this cycle.

Behaviour:
- Registered state:
  - busy[ENTRY_NUM].
  - rr_ptr[ENTRY_SEL].
- Reset (reset_ni low, asynchronous):
  - busy=0, rr_ptr=0.
  - While reset is asserted: alloc_ok_o=0, we_vec_o=0, issue_valid_o=0, issue_idx_o=0, alloc_1_idx_o=alloc_2_idx_o=0, busy_vec_o=0, free_count_o=ENTRY_NUM.
- Allocation (combinational grant, registered effect):
  - req_cnt = alloc_req_1_i + alloc_req_2_i.
  - Free entries are those with busy=0, judged on the current registered busy. An entry issued this cycle is NOT reusable until the next cycle.
  - alloc_1_idx_o = lowest-index free entry; alloc_2_idx_o = second-lowest free entry. Both are 0 when none exists.
  - Grant is all-or-nothing: alloc_ok_o = (req_cnt != 0) & (free_count_o >= req_cnt) & ~flush_i.
  - Partial grants are never given. On a deny, dispatch stalls and re-presents both slots.
  - When granted: we_vec_o sets the bit of each granted index, and busy of each granted entry is set at the next edge.
  - alloc_req_2_i without alloc_req_1_i is illegal; simulation assertion only.
- Issue selection:
  - cand = ready_vec_i & busy.
  - issue_valid_o = (cand != 0) & ~flush_i.
  - issue_idx_o = first set bit of cand searching upward from rr_ptr, wrapping at ENTRY_NUM-1 → 0.
  - Handshake fires when issue_valid_o & issue_ready_i.
    - Next edge: busy[issue_idx_o] is cleared and rr_ptr <= issue_idx_o+1, mod ENTRY_NUM with natural wrap.
    - No fire: rr_ptr is held.
  - issue_idx_o must stay stable while valid and not accepted, unless a higher-priority entry becomes ready.
- Simultaneous events:
  - Allocate and issue in the same cycle are independent. A granted index is never the issued index, because granted entries are not busy.
  - Allocate when full: alloc_ok_o=0, no state change.
  - A single request with exactly one entry free is granted.
- flush_i:
  - Next edge: busy=0 and rr_ptr=0.
  - Same cycle: alloc_ok_o, we_vec_o and issue_valid_o are forced to 0.
  - Flush wins over all simultaneous alloc and issue events.
- Latency:
  - Grant to busy visible: 1 cycle.
  - Handshake to entry free: 1 cycle.
  - Entry ready to issue_valid_o: 0 cycles, combinational.

Decomposition:
- Shared constants belong in the shared consts header:
  - `ALU_ENT_NUM and `ALU_ENT_SEL, defining the defaults of ENTRY_NUM and ENTRY_SEL.
- Sub-module rs_prio_enc: parameterised find-first-set returning a valid flag and an index.
  - Instantiated for free-entry search: once on ~busy, once on ~busy with the first hit masked.
  - Instantiated for issue search: on cand masked at and above rr_ptr, then on the unmasked cand as fallback (rotating round-robin).

Test Plan:
- Reset then single alloc: reset_ni pulse, then alloc_req_1_i=1 → alloc_ok_o=1, alloc_1_idx_o=0, we_vec_o=8'h01; next cycle busy_vec_o=8'h01, free_count_o=7.
- Dual alloc until full: four cycles of dual requests → indices (0,1),(2,3),(4,5),(6,7); a fifth dual request gives alloc_ok_o=0, we_vec_o=0. With one entry free, a dual request is denied and a single request is granted.
- Round-robin issue: all busy, ready_vec_i=8'hFF, issue_ready_i=1 every cycle → issue_idx_o sequence 0,1,...,7. With ready only {2,5} and rr_ptr=3 → 5 first, then 2.
- Backpressure: ready entry 4, issue_ready_i=0 for 3 cycles → issue_valid_o=1, issue_idx_o=4 held, busy[4] stays 1; on accept, busy[4]=0 next cycle.
- Same-cycle issue and alloc when full: issue entry 0 accepted while dual alloc is requested → alloc denied this cycle; next cycle a single alloc returns idx 0.
- Flush and async reset: with busy=8'hFF, assert flush_i plus requests → alloc_ok_o=0 and issue_valid_o=0, then busy_vec_o=0 and free_count_o=8. Drop reset_ni mid-cycle → busy_vec_o=0 immediately, without waiting for a clock edge.
